// File: rtl/alu_share_ctrl.sv
// Arbiter/sequencer sharing one registered 8-bit adder among NUM_REQ requesters.
// Define ALU_SHARE_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module alu_share_ctrl #(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_a,
   input  logic [8*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [7:0]           rsp_data,
   output logic                 busy,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic                 alu_op,
   input  logic [7:0]           alu_s
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t             state, state_n;
   logic [NUM_REQ-1:0] win_q, win_n, win_oh;
   logic [NUM_REQ-1:0] gnt_n, rsp_valid_n;
   logic [7:0]         rsp_data_n, alu_a_n, alu_b_n, sel_a, sel_b;
   logic               alu_op_n;
   logic               win_found;
   logic [PW-1:0]      win_idx, cand;
`ifdef ALU_SHARE_RR_EN
   logic [PW-1:0]      rr_ptr, rr_ptr_n;
`endif

   // Winner selection: first set request scanning upward (from rr_ptr when round-robin).
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_SHARE_RR_EN
         cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
`else
         cand = PW'(k);
`endif
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_oh = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (PW'(k) == win_idx) begin
            win_oh[k] = 1'b1;
            sel_a     = req_a[8*k +: 8];
            sel_b     = req_b[8*k +: 8];
         end
      end
   end

   // NOTE: every output of a combinational block gets a default before the case;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_n     = state;
      gnt_n       = '0;
      alu_op_n    = 1'b0;
      alu_a_n     = alu_a;
      alu_b_n     = alu_b;
      rsp_valid_n = '0;
      rsp_data_n  = rsp_data;
      win_n       = win_q;
`ifdef ALU_SHARE_RR_EN
      rr_ptr_n    = rr_ptr;
`endif
      case (state)
         IDLE: begin
            if (win_found) begin
               state_n  = ISSUE;
               gnt_n    = win_oh;
               alu_op_n = 1'b1;
               alu_a_n  = sel_a;
               alu_b_n  = sel_b;
               win_n    = win_oh;
`ifdef ALU_SHARE_RR_EN
               rr_ptr_n = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
            end
         end
         ISSUE:   state_n = CAPTURE;
         CAPTURE: begin
            // The adder registered its sum at the end of ISSUE; forward it now.
            state_n     = IDLE;
            rsp_valid_n = win_q;
            rsp_data_n  = alu_s;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= 1'b0;
         win_q     <= '0;
`ifdef ALU_SHARE_RR_EN
         rr_ptr    <= '0;
`endif
      end else begin
         state     <= state_n;
         gnt       <= gnt_n;
         rsp_valid <= rsp_valid_n;
         rsp_data  <= rsp_data_n;
         alu_a     <= alu_a_n;
         alu_b     <= alu_b_n;
         alu_op    <= alu_op_n;
         win_q     <= win_n;
`ifdef ALU_SHARE_RR_EN
         rr_ptr    <= rr_ptr_n;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural registered adder and a response scoreboard.
module tb_alu_share_ctrl;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_a = '0;
   logic [8*N-1:0] req_b = '0;
   logic [N-1:0]   gnt, rsp_valid;
   logic [7:0]     rsp_data, alu_a, alu_b;
   logic [7:0]     alu_s = 8'hEE;
   logic           busy, alu_op;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [N-1:0] oh;
      logic [7:0]   sum;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_share_ctrl #(.NUM_REQ(N)) dut (
      .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s)
   );

   // Shared adder: registers the sum when op-enable is high, never reset.
   always @(posedge clk) if (alu_op) alu_s <= alu_a + alu_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int exp_winner(input int g);
`ifdef ALU_SHARE_RR_EN
      return g % N;
`else
      return 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[8*i +: 8] = a;
      req_b[8*i +: 8] = b;
   endtask

   task automatic push(input int i, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.oh  = onehot(i);
      e.sum = a + b;
      sb.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("drain", 32'(sb.size()), 0);
      check("drain_busy", 32'(busy), 0);
   endtask

   task automatic apply_reset();
      tick();
      reset = 1'b1;
      req   = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expected result.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rsp_valid != '0) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 0);
         end else begin
            e = sb.pop_front();
            check("rsp_oh", 32'(rsp_valid), 32'(e.oh));
            check("rsp_data", 32'(rsp_data), 32'(e.sum));
         end
      end
   end

   task automatic run_single(input int i, input logic [7:0] a, input logic [7:0] b);
      tick();
      set_op(i, a, b);
      req[i] = 1'b1;
      push(i, a, b);
      @(negedge clk);
      check("s_gnt_T", 32'(gnt), 0);
      check("s_busy_T", 32'(busy), 0);
      @(negedge clk);
      check("s_gnt", 32'(gnt), 32'(onehot(i)));
      check("s_op", 32'(alu_op), 1);
      check("s_alu_a", 32'(alu_a), 32'(a));
      check("s_alu_b", 32'(alu_b), 32'(b));
      tick();
      req[i] = 1'b0;
      @(negedge clk);
      check("s_op_off", 32'(alu_op), 0);
      check("s_gnt_off", 32'(gnt), 0);
      check("s_busy_cap", 32'(busy), 1);
      @(negedge clk);
      check("s_rsp_vld", 32'(rsp_valid), 32'(onehot(i)));
      check("s_busy_idle", 32'(busy), 0);
      drain();
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      logic [N-1:0] eg;
      logic [7:0]   a, b;

      // Reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rspv", 32'(rsp_valid), 0);
      check("rst_data", 32'(rsp_data), 0);
      check("rst_op", 32'(alu_op), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);

      // Single request and 8-bit wrap-around
      run_single(0, 8'h12, 8'h34);
      run_single(2, 8'hF0, 8'h20);

      // All requesters continuously asserted, five grants
      apply_reset();
      tick();
      for (int i = 0; i < N; i++) set_op(i, 8'(16 * i + 3), 8'(i + 1));
      for (int g = 0; g < 5; g++) begin
         a = 8'(16 * exp_winner(g) + 3);
         b = 8'(exp_winner(g) + 1);
         push(exp_winner(g), a, b);
      end
      req = '1;
      for (int c = 0; c <= 15; c++) begin
         @(negedge clk);
         eg = (c >= 1 && (c - 1) % 3 == 0) ? onehot(exp_winner((c - 1) / 3)) : '0;
         check("all_gnt", 32'(gnt), 32'(eg));
         check("all_op", 32'(alu_op), 32'(eg != '0));
         check("all_rspv", 32'(rsp_valid != '0), 32'(c >= 3 && c % 3 == 0));
         if (c == 13) begin
            tick();
            req = '0;
         end
      end
      drain();

      // Back-to-back: requester 1 re-requests in its own rsp_valid cycle
      tick();
      set_op(1, 8'h21, 8'h42);
      req[1] = 1'b1;
      push(1, 8'h21, 8'h42);
      @(negedge clk);
      @(negedge clk);
      check("b2b_gnt1", 32'(gnt), 32'(onehot(1)));
      tick();
      req[1] = 1'b0;
      @(negedge clk);
      check("b2b_busy_cap", 32'(busy), 1);
      tick();
      set_op(1, 8'h80, 8'h81);
      req[1] = 1'b1;
      push(1, 8'h80, 8'h81);
      @(negedge clk);
      check("b2b_busy_gap", 32'(busy), 0);
      check("b2b_op_gap", 32'(alu_op), 0);
      @(negedge clk);
      check("b2b_gnt2", 32'(gnt), 32'(onehot(1)));
      check("b2b_op2", 32'(alu_op), 1);
      check("b2b_busy2", 32'(busy), 1);
      tick();
      req[1] = 1'b0;
      @(negedge clk);
      check("b2b_op_off", 32'(alu_op), 0);
      drain();

      // A request arriving during ISSUE waits for IDLE and gets its own sum
      tick();
      set_op(0, 8'h01, 8'h02);
      req[0] = 1'b1;
      push(0, 8'h01, 8'h02);
      @(negedge clk);
      @(negedge clk);
      check("iss_gnt0", 32'(gnt), 32'(onehot(0)));
      set_op(3, 8'h77, 8'h11);
      req = 4'b1000;
      push(3, 8'h77, 8'h11);
      @(negedge clk);
      check("iss_ign_cap", 32'(gnt), 0);
      @(negedge clk);
      check("iss_ign_idle", 32'(gnt), 0);
      @(negedge clk);
      check("iss_gnt3", 32'(gnt), 32'(onehot(3)));
      tick();
      req = '0;
      drain();

      // Reset during CAPTURE drops the operation; reset beats a same-cycle request
      tick();
      set_op(2, 8'hAA, 8'h55);
      req = 4'b0100;
      @(negedge clk);
      @(negedge clk);
      check("rc_gnt2", 32'(gnt), 32'(onehot(2)));
      tick();
      req   = '0;
      reset = 1'b1;
      @(negedge clk);
      check("rc_busy_cap", 32'(busy), 1);
      tick();
      for (int i = 0; i < N; i++) set_op(i, 8'(i + 5), 8'(i + 6));
      req = '1;
      @(negedge clk);
      check("rc_gnt", 32'(gnt), 0);
      check("rc_rspv", 32'(rsp_valid), 0);
      check("rc_data", 32'(rsp_data), 0);
      check("rc_op", 32'(alu_op), 0);
      check("rc_busy", 32'(busy), 0);
      check("rc_alu_a", 32'(alu_a), 0);
      check("rc_alu_b", 32'(alu_b), 0);
      tick();
      reset = 1'b0;
      push(0, 8'h05, 8'h06);
      @(negedge clk);
      check("rc_rst_wins", 32'(gnt), 0);
      @(negedge clk);
      check("rc_gnt_after", 32'(gnt), 32'(onehot(0)));
      tick();
      req = '0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
